setup_reg_frame: RTL
====================

Name: setup_reg_frame

Overview:
Parametrised serial-in/parallel-out setup register. It receives fixed-length serial configuration frames one bit per enabled clock. It extracts a contiguous field from each frame and presents it on a parallel output. Used wherever a block needs a few setup bits delivered over a single serial line; the output changes only on complete frames, so downstream logic never sees a half-loaded value.

Parameters:
FRAME_LEN, 32, bits per frame; legal range 2..256
FIELD_W, 8, width of the extracted field / parallel_out
FIELD_LSB, 23, frame bit index that lands in parallel_out[0]; requires FIELD_LSB+FIELD_W <= FRAME_LEN (<= FRAME_LEN-1 with SETUP_PARITY_EN)

Ports:
clk_in  input  1  clock, all state on rising edge
rst_n_in  input  1  asynchronous active-low reset
en_in  input  1  qualifies serial_in; one frame bit is accepted per cycle with en_in=1
serial_in  input  1  serial data; the first accepted bit of a frame is index 0
frame_rst_in  input  1  synchronous frame resync
parallel_out  output  FIELD_W  committed field value
valid_out  output  1  one-cycle pulse on each committed frame
busy_out  output  1  1 while a frame is partially received (bit counter != 0)
parity_err_out  output  1  one-cycle pulse on a rejected frame (SETUP_PARITY_EN only, else 0)

Behaviour:
- Counter width: clog2(FRAME_LEN), computed internally. Shadow register is FIELD_W bits.
- Reset (rst_n_in=0, asynchronous):
  - bit counter = 0, shadow = 0
  - parallel_out = 0, valid_out = 0, parity_err_out = 0, busy_out = 0
- Per-cycle priority:
  1. frame_rst_in = 1:
     - counter <= 0, shadow <= 0, valid_out <= 0, parity_err_out <= 0
     - parallel_out holds; en_in and serial_in are ignored
  2. en_in = 0:
     - all state holds; valid_out and parity_err_out <= 0
  3. en_in = 1, counter = k:
     - if FIELD_LSB <= k < FIELD_LSB+FIELD_W: shadow[k-FIELD_LSB] <= serial_in; otherwise the bit is discarded (except the parity bit, below)
     - if k < FRAME_LEN-1: counter <= k+1
     - if k = FRAME_LEN-1: counter <= 0 (wrap), then commit:
       - parallel_out <= next-shadow value, including this bit if it lies in the field
       - valid_out <= 1 for exactly one cycle
       - shadow <= 0
- Latency: parallel_out and valid_out update on the clock edge that samples the last frame bit. Both are visible in the following cycle.
- Back-to-back frames are supported with no gap cycles. Bit 0 of the next frame can be accepted in the cycle valid_out is high.
- Partial frames never alter parallel_out.
- Reset asserted mid-frame discards the partial frame and zeroes parallel_out. frame_rst_in mid-frame discards the partial frame and keeps parallel_out.
- en_in gaps of any length mid-frame are transparent: the counter and shadow hold.

Optional Feature:
SETUP_PARITY_EN
- Defined: frame bit FRAME_LEN-1 is an even-parity bit over the FIELD_W field bits.
  - On commit, if XOR(field bits, parity bit) = 0: normal commit and valid_out pulse.
  - Otherwise: parallel_out holds, valid_out stays 0, parity_err_out pulses 1 cycle. Counter and shadow reset as for a normal frame end.
- Not defined: bit FRAME_LEN-1 is treated as an ordinary frame bit, and parity_err_out is tied 0.

Test Plan:
1. Defaults. Reset, then a 32-bit frame with bits 23..30 = 0xA5 (bit 23 = 1), others 0 -> parallel_out = 0xA5, valid_out high one cycle after bit 31; busy_out low afterwards.
2. Same frame with en_in low for 5 cycles after bit 10 and again after bit 27 -> identical result. parallel_out stays 0 until the final bit.
3. Frame 0x3C, then frame 0xC3 back-to-back, en_in held 1 -> two valid_out pulses exactly 32 cycles apart. parallel_out reads 0x3C, then 0xC3.
4. After 0x3C is committed, send 20 bits, pulse frame_rst_in, then a full 0x81 frame -> parallel_out stays 0x3C during the aborted frame, then becomes 0x81 with one valid_out pulse.
5. rst_n_in low mid-frame, asynchronously between clock edges -> parallel_out = 0 and busy_out = 0 immediately. The next full 0x5A frame yields 0x5A.
6. SETUP_PARITY_EN defined:
   - field 0x07 with bit 31 = 1 -> commit and valid_out pulse
   - field 0x07 with bit 31 = 0 -> parity_err_out pulse, parallel_out unchanged, no valid_out

Source files
------------

// File: rtl/setup_reg_frame_if.sv
// Serial setup-frame bus: serial bit stream in, committed field and status out.
interface setup_reg_frame_if #(
    parameter int FIELD_W = 8
);
    logic               en_in;
    logic               serial_in;
    logic               frame_rst_in;
    logic [FIELD_W-1:0] parallel_out;
    logic               valid_out;
    logic               busy_out;
    logic               parity_err_out;

    modport master (
        output en_in, serial_in, frame_rst_in,
        input  parallel_out, valid_out, busy_out, parity_err_out
    );

    modport slave (
        input  en_in, serial_in, frame_rst_in,
        output parallel_out, valid_out, busy_out, parity_err_out
    );
endinterface

// File: rtl/setup_reg_frame.sv
// Serial-in/parallel-out setup register committing one field per complete frame.
// Optional even-parity check on the last frame bit when SETUP_PARITY_EN is defined.
module setup_reg_frame #(
    parameter int FRAME_LEN = 32,
    parameter int FIELD_W   = 8,
    parameter int FIELD_LSB = 23
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    setup_reg_frame_if.slave    bus
);
    localparam int                CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]   cnt_p0;
    logic [FIELD_W-1:0] shadow_p0;
    logic [FIELD_W-1:0] shadow_nxt;
    logic               parity_ok;
    logic [FIELD_W-1:0] field_p1;
    logic               vld_p1;
    logic               perr_p1;

    // Shadow with the current bit merged in, so the final bit can be committed directly.
    always_comb begin
        shadow_nxt = shadow_p0;
        if (bus.en_in) begin
            for (int i = 0; i < FIELD_W; i++) begin
                if (int'(cnt_p0) == FIELD_LSB + i) shadow_nxt[i] = bus.serial_in;
            end
        end
    end

`ifdef SETUP_PARITY_EN
    assign parity_ok = ~(^{shadow_nxt, bus.serial_in});
`else
    assign parity_ok = 1'b1;
`endif

    // Stage p0 -> p1: bit capture, frame end commit or reject
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_p0    <= '0;
            shadow_p0 <= '0;
            field_p1  <= '0;
            vld_p1    <= 1'b0;
            perr_p1   <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            perr_p1 <= 1'b0;
            if (bus.frame_rst_in) begin
                cnt_p0    <= '0;
                shadow_p0 <= '0;
            end else if (bus.en_in) begin
                if (cnt_p0 == LAST) begin
                    cnt_p0    <= '0;
                    shadow_p0 <= '0;
                    if (parity_ok) begin
                        field_p1 <= shadow_nxt;
                        vld_p1   <= 1'b1;
                    end else begin
                        perr_p1  <= 1'b1;
                    end
                end else begin
                    cnt_p0    <= cnt_p0 + 1'b1;
                    shadow_p0 <= shadow_nxt;
                end
            end
        end
    end

    assign bus.parallel_out   = field_p1;
    assign bus.valid_out      = vld_p1;
    assign bus.busy_out       = (cnt_p0 != '0);
    assign bus.parity_err_out = perr_p1;
endmodule
